dvi_pixel_capture: RTL and testbench

- Receive side of the 12-bit multiplexed DVI pixel bus that the display path drives.
- Takes word-serial GBRG input with DE/hsync/vsync, all sampled on one clock running at 2x pixel rate (two 12-bit words per pixel).
- Reassembles 24-bit RGB pixels and tracks pixel_x/pixel_y.
- Pushes pixels plus start-of-frame/end-of-line tags into a downstream write FIFO using a full/write handshake.

---
 rtl/dvi_pixel_capture.sv | 242 ++++++++++++++++++++++++
 tb/tb_dvi_pixel_capture.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dvi_pixel_capture.sv
// dvi_pixel_capture
//   Receive side of the 12-bit word-multiplexed DVI pixel bus. Two words per
//   pixel arrive on a clock running at twice the pixel rate:
//     word0 = {g[3:0], b[7:0]}, word1 = {r[7:0], g[7:4]}.
//   Pixels are reassembled to 24-bit RGB, tagged with start-of-frame and
//   end-of-line, and pushed into a downstream FIFO. Line/frame length,
//   word alignment and FIFO overflow are tracked with sticky flags.
//
// Ports
//   clk        capture clock (2x pixel rate)
//   rst_n      asynchronous active-low reset
//   d_in       multiplexed pixel word
//   de_in      data enable (active video)
//   hsync_in   horizontal sync, active level set by HSYNC_POL
//   vsync_in   vertical sync, active level set by VSYNC_POL
//   fifo_full  downstream FIFO cannot take a write this cycle
//   clr_err    synchronous clear of overflow/err_align/err_len
//   wr_en      one-cycle write strobe
//   wr_data    {eol, sof, r[7:0], g[7:0], b[7:0]}
//   pixel_x    x of the pixel on wr_data
//   pixel_y    y of the pixel on wr_data
//   locked     a full error-free frame was captured since the last resync
//   overflow   sticky: pixel dropped because fifo_full
//   err_align  sticky: DE fell after an odd number of words
//   err_len    sticky: line or frame length mismatch
module dvi_pixel_capture #(
  parameter int H_ACTIVE  = 640,
  parameter int V_ACTIVE  = 480,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] d_in,
  input  logic        de_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        fifo_full,
  input  logic        clr_err,
  output logic        wr_en,
  output logic [25:0] wr_data,
  output logic [9:0]  pixel_x,
  output logic [9:0]  pixel_y,
  output logic        locked,
  output logic        overflow,
  output logic        err_align,
  output logic        err_len
);

  localparam logic [9:0] H_ACT_W = 10'(H_ACTIVE);
  localparam logic [9:0] H_LAST  = 10'(H_ACTIVE - 1);
  localparam logic [9:0] V_ACT_W = 10'(V_ACTIVE);
  localparam logic [9:0] CNT_MAX = 10'h3FF;

  typedef enum logic [1:0] {WAIT_VS, RUN, DROP} state_t;

  // Reset asserts asynchronously but releases on a clock edge.
  logic rst_meta_q, rst_sync_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_meta_q <= 1'b0;
      rst_sync_q <= 1'b0;
    end else begin
      rst_meta_q <= 1'b1;
      rst_sync_q <= rst_meta_q;
    end
  end

  // Input stage. Syncs are stored already normalised to active-high so that
  // the reset value (0) reads as "inactive" regardless of polarity.
  logic [11:0] d_q;
  logic        de_q, de_prev_q, hs_act_q, vs_act_q, vs_prev_q;
  always_ff @(posedge clk or negedge rst_sync_q) begin
    if (!rst_sync_q) begin
      d_q       <= '0;
      de_q      <= 1'b0;
      de_prev_q <= 1'b0;
      hs_act_q  <= 1'b0;
      vs_act_q  <= 1'b0;
      vs_prev_q <= 1'b0;
    end else begin
      d_q       <= d_in;
      de_q      <= de_in;
      de_prev_q <= de_q;
      hs_act_q  <= (hsync_in == HSYNC_POL);
      vs_act_q  <= (vsync_in == VSYNC_POL);
      vs_prev_q <= vs_act_q;
    end
  end

  logic   de_rise, de_fall, vs_edge, cur_phase, pix_ready;
  state_t state_q;
  logic   phase_q, phase_d;
  logic [9:0] x_q, x_d, y_q, y_d;

  assign de_rise   = de_q & ~de_prev_q;
  assign de_fall   = ~de_q & de_prev_q;
  assign vs_edge   = vs_act_q & ~vs_prev_q;
  // The first word after DE rises is always word0.
  assign cur_phase = de_rise ? 1'b0 : phase_q;
  assign pix_ready = de_q & cur_phase;

  always_comb begin
    x_d     = x_q;
    y_d     = y_q;
    phase_d = phase_q;
    if (de_q) phase_d = ~cur_phase;
    if (de_rise) x_d = '0;
    if (pix_ready && x_q != CNT_MAX) x_d = x_q + 10'd1;
    if (de_fall) begin
      x_d     = '0;
      phase_d = 1'b0;
      if (y_q != CNT_MAX) y_d = y_q + 10'd1;
    end
    // vsync clear has priority so a line starting on the same cycle is y=0.
    if (vs_edge) y_d = '0;
  end

  // Assembly stage: word0 held, pixel built when word1 arrives.
  logic [11:0] hold_q;
  logic        asm_valid_q;
  logic [25:0] asm_data_q;
  logic [9:0]  asm_x_q, asm_y_q;
  always_ff @(posedge clk or negedge rst_sync_q) begin
    if (!rst_sync_q) begin
      phase_q     <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      hold_q      <= '0;
      asm_valid_q <= 1'b0;
      asm_data_q  <= '0;
      asm_x_q     <= '0;
      asm_y_q     <= '0;
    end else begin
      phase_q     <= phase_d;
      x_q         <= x_d;
      y_q         <= y_d;
      asm_valid_q <= pix_ready;
      if (de_q && !cur_phase) hold_q <= d_q;
      if (pix_ready) begin
        asm_data_q <= {(x_q == H_LAST), (x_q == '0 && y_q == '0),
                       d_q[11:4], d_q[3:0], hold_q[11:8], hold_q[7:0]};
        asm_x_q    <= x_q;
        asm_y_q    <= y_q;
      end
    end
  end

  // Error events; line and frame checks only count while capturing.
  logic in_run, ovf_ev, align_ev, len_line_ev, len_frame_ev;
  assign in_run       = (state_q == RUN);
  assign ovf_ev       = in_run & asm_valid_q & fifo_full;
  assign align_ev     = in_run & de_fall & phase_q;
  assign len_line_ev  = in_run & de_fall & (x_q != H_ACT_W);
  assign len_frame_ev = in_run & vs_edge & (y_q != V_ACT_W);

  // Output stage and capture state machine.
  logic        wr_en_q, locked_q, overflow_q, err_align_q, err_len_q, frame_err_q;
  logic [25:0] wr_data_q;
  logic [9:0]  pixel_x_q, pixel_y_q;
  always_ff @(posedge clk or negedge rst_sync_q) begin
    if (!rst_sync_q) begin
      state_q     <= WAIT_VS;
      wr_en_q     <= 1'b0;
      wr_data_q   <= '0;
      pixel_x_q   <= '0;
      pixel_y_q   <= '0;
      locked_q    <= 1'b0;
      overflow_q  <= 1'b0;
      err_align_q <= 1'b0;
      err_len_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      wr_en_q <= 1'b0;
      case (state_q)
        WAIT_VS: begin
          if (vs_edge) begin
            state_q     <= RUN;
            frame_err_q <= 1'b0;
          end
        end
        RUN: begin
          if (vs_edge) begin
            locked_q    <= ~frame_err_q & (y_q == V_ACT_W);
            frame_err_q <= 1'b0;
          end
          if (asm_valid_q) begin
            if (fifo_full) begin
              // Drop the rest of the frame and resync on the next vsync.
              state_q     <= DROP;
              locked_q    <= 1'b0;
              frame_err_q <= 1'b1;
            end else begin
              wr_en_q   <= 1'b1;
              wr_data_q <= asm_data_q;
              pixel_x_q <= asm_x_q;
              pixel_y_q <= asm_y_q;
            end
          end
        end
        DROP: begin
          locked_q <= 1'b0;
          if (vs_edge) begin
            state_q     <= RUN;
            frame_err_q <= 1'b0;
          end
        end
        default: state_q <= WAIT_VS;
      endcase

      // Clear first so a simultaneous new event wins.
      if (clr_err) begin
        overflow_q  <= 1'b0;
        err_align_q <= 1'b0;
        err_len_q   <= 1'b0;
      end
      if (ovf_ev) overflow_q <= 1'b1;
      if (align_ev) err_align_q <= 1'b1;
      if (len_line_ev || len_frame_ev) err_len_q <= 1'b1;
      if (align_ev || len_line_ev) begin
        locked_q    <= 1'b0;
        frame_err_q <= 1'b1;
      end
      if (len_frame_ev) locked_q <= 1'b0;
    end
  end

  // Horizontal sync carries no information beyond DE for this receiver; it is
  // registered with the other inputs only to keep them time-aligned.
  logic hs_unused;
  assign hs_unused = hs_act_q;

  assign wr_en     = wr_en_q;
  assign wr_data   = wr_data_q;
  assign pixel_x   = pixel_x_q;
  assign pixel_y   = pixel_y_q;
  assign locked    = locked_q;
  assign overflow  = overflow_q;
  assign err_align = err_align_q;
  assign err_len   = err_len_q;

endmodule

// File: tb/tb_dvi_pixel_capture.sv
// Directed testbench for dvi_pixel_capture, using a reduced frame size
// (120x8) so whole frames stay short.
module tb_dvi_pixel_capture;

  localparam int H = 120;
  localparam int V = 8;
  localparam logic [11:0] WA0 = 12'hA55;
  localparam logic [11:0] WA1 = 12'h3C7;
  localparam logic [23:0] RGB_A = 24'h3C7A55;  // r=3C g=7A b=55
  localparam logic [11:0] WB0 = 12'h123;
  localparam logic [11:0] WB1 = 12'h456;
  localparam logic [23:0] RGB_B = 24'h456123;  // r=45 g=61 b=23

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] d_in = '0;
  logic        de_in = 1'b0;
  logic        hsync_in = 1'b1;
  logic        vsync_in = 1'b1;
  logic        fifo_full = 1'b0;
  logic        clr_err = 1'b0;
  logic        wr_en;
  logic [25:0] wr_data;
  logic [9:0]  pixel_x, pixel_y;
  logic        locked, overflow, err_align, err_len;

  int checks = 0;
  int failures = 0;
  int pcyc = 0;

  typedef struct {
    logic [25:0] data;
    logic [9:0]  x;
    logic [9:0]  y;
    int          cyc;
  } wr_rec_t;
  wr_rec_t wq[$];

  dvi_pixel_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .HSYNC_POL(1'b0), .VSYNC_POL(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .d_in(d_in), .de_in(de_in), .hsync_in(hsync_in),
    .vsync_in(vsync_in), .fifo_full(fifo_full), .clr_err(clr_err), .wr_en(wr_en),
    .wr_data(wr_data), .pixel_x(pixel_x), .pixel_y(pixel_y), .locked(locked),
    .overflow(overflow), .err_align(err_align), .err_len(err_len)
  );

  always #5 clk = ~clk;
  always @(posedge clk) pcyc <= pcyc + 1;

  // Record every write with the posedge count it followed.
  always @(negedge clk) begin
    if (wr_en === 1'b1) wq.push_back('{wr_data, pixel_x, pixel_y, pcyc});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic vsync_pulse();
    vsync_in = 1'b0;
    ticks(4);
    vsync_in = 1'b1;
    ticks(6);
  endtask

  task automatic clr_pulse();
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    tick();
  endtask

  // Drives one DE-high run of `words` words; fifo_full is high during the
  // cycle that starts iteration ff_word. k1 = posedge that sampled word1.
  task automatic send_line(input int words, input int ff_word,
                           input logic [11:0] w0, input logic [11:0] w1, output int k1);
    k1 = -1;
    for (int i = 0; i < words; i++) begin
      de_in = 1'b1;
      d_in = (i % 2 == 0) ? w0 : w1;
      fifo_full = (i == ff_word);
      tick();
      if (i == 1) k1 = pcyc;
    end
    de_in = 1'b0;
    d_in = '0;
    fifo_full = 1'b0;
    ticks(2);
    hsync_in = 1'b0;
    ticks(4);
    hsync_in = 1'b1;
    ticks(10);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ticks(3);
    checks++;
    if ({wr_en, wr_data, pixel_x, pixel_y, locked, overflow, err_align, err_len} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got wr_en=%b data=%h x=%0d y=%0d flags=%b%b%b%b required all 0",
               wr_en, wr_data, pixel_x, pixel_y, locked, overflow, err_align, err_len);
    end
    rst_n = 1'b1;
    ticks(4);
    $display("test_reset done");
  endtask

  task automatic test_line();
    int k1, bad_rgb, bad_sof, bad_eol, bad_x, bad_gap, lat;
    vsync_pulse();
    wq.delete();
    send_line(2 * H, -1, WA0, WA1, k1);
    bad_rgb = 0; bad_sof = 0; bad_eol = 0; bad_x = 0; bad_gap = 0;
    foreach (wq[i]) begin
      if (wq[i].data[23:0] !== RGB_A) bad_rgb++;
      if (wq[i].data[24] !== (i == 0)) bad_sof++;
      if (wq[i].data[25] !== (i == H - 1)) bad_eol++;
      if (int'(wq[i].x) != i || wq[i].y !== 10'd0) bad_x++;
      if (i > 0 && wq[i].cyc - wq[i-1].cyc != 2) bad_gap++;
    end
    lat = (wq.size() > 0) ? wq[0].cyc - k1 : -1;
    checks++;
    if (wq.size() != H) begin
      failures++; $display("FAIL line_count: got %0d required %0d", wq.size(), H);
    end
    checks++;
    if (bad_rgb !== 0) begin
      failures++; $display("FAIL line_rgb: bad=%0d required 0", bad_rgb);
    end
    checks++;
    if (bad_sof !== 0 || bad_eol !== 0) begin
      failures++; $display("FAIL line_tags: bad_sof=%0d bad_eol=%0d required 0", bad_sof, bad_eol);
    end
    checks++;
    if (bad_x !== 0) begin
      failures++; $display("FAIL line_xy: bad=%0d required 0", bad_x);
    end
    checks++;
    if (bad_gap !== 0) begin
      failures++; $display("FAIL line_spacing: bad=%0d required 0", bad_gap);
    end
    checks++;
    if (lat != 2) begin
      failures++; $display("FAIL line_latency: got %0d required 2", lat);
    end
    checks++;
    if ({overflow, err_align, err_len} !== 3'b000) begin
      failures++; $display("FAIL line_flags: got %b required 000", {overflow, err_align, err_len});
    end
    $display("test_line done: writes=%0d", wq.size());
  endtask

  task automatic test_frame();
    int k1, bad;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    ticks(4);
    vsync_pulse();
    wq.delete();
    for (int l = 0; l < V; l++) send_line(2 * H, -1, WA0, WA1, k1);
    bad = 0;
    foreach (wq[i]) begin
      if (int'(wq[i].x) != i % H || int'(wq[i].y) != i / H) bad++;
      if (wq[i].data[25] !== (i % H == H - 1)) bad++;
      if (wq[i].data[24] !== (i == 0)) bad++;
      if (wq[i].data[23:0] !== RGB_A) bad++;
    end
    checks++;
    if (wq.size() != H * V) begin
      failures++; $display("FAIL frame_count: got %0d required %0d", wq.size(), H * V);
    end
    checks++;
    if (bad !== 0) begin
      failures++; $display("FAIL frame_content: bad=%0d required 0", bad);
    end
    checks++;
    if (wq.size() > 0 && (int'(wq[$].y) != V - 1 || wq[$].data[25] !== 1'b1)) begin
      failures++; $display("FAIL frame_last: got y=%0d eol=%b required y=%0d eol=1",
                           wq[$].y, wq[$].data[25], V - 1);
    end
    checks++;
    if (locked !== 1'b0) begin
      failures++; $display("FAIL frame_locked_early: got %b required 0", locked);
    end
    vsync_pulse();
    checks++;
    if ({locked, overflow, err_align, err_len} !== 4'b1000) begin
      failures++; $display("FAIL frame_locked: got lock/ovf/al/len=%b required 1000",
                           {locked, overflow, err_align, err_len});
    end
    $display("test_frame done: writes=%0d", wq.size());
  endtask

  task automatic test_overflow();
    int k1, n_before;
    wq.delete();
    for (int l = 0; l < V; l++) begin
      // Iteration 2*100+3 is the cycle where pixel x=100 is ready.
      send_line(2 * H, (l == 5) ? 203 : -1, WA0, WA1, k1);
      if (l == 5) begin
        checks++;
        if ({overflow, locked} !== 2'b10) begin
          failures++; $display("FAIL ovf_flag: got ovf/locked=%b required 10", {overflow, locked});
        end
      end
    end
    n_before = wq.size();
    checks++;
    if (n_before != 5 * H + 100) begin
      failures++; $display("FAIL ovf_count: got %0d required %0d", n_before, 5 * H + 100);
    end
    checks++;
    if (n_before > 0 && (wq[$].x !== 10'd99 || wq[$].y !== 10'd5)) begin
      failures++; $display("FAIL ovf_last: got x=%0d y=%0d required x=99 y=5", wq[$].x, wq[$].y);
    end
    vsync_pulse();
    wq.delete();
    send_line(2 * H, -1, WA0, WA1, k1);
    checks++;
    if (wq.size() != H || wq[0].data[24] !== 1'b1 || wq[0].x !== 10'd0 || wq[0].y !== 10'd0) begin
      failures++; $display("FAIL ovf_resync: got n=%0d sof=%b x=%0d y=%0d required n=%0d sof=1 x=0 y=0",
                           wq.size(), wq[0].data[24], wq[0].x, wq[0].y, H);
    end
    checks++;
    if (overflow !== 1'b1) begin
      failures++; $display("FAIL ovf_sticky: got %b required 1", overflow);
    end
    $display("test_overflow done");
  endtask

  task automatic test_full_ignored();
    int k1;
    clr_pulse();
    checks++;
    if (overflow !== 1'b0) begin
      failures++; $display("FAIL ovf_clear: got %b required 0", overflow);
    end
    wq.delete();
    // Iteration 24 falls on a cycle with no pixel ready.
    send_line(2 * H, 24, WA0, WA1, k1);
    checks++;
    if (wq.size() != H || overflow !== 1'b0) begin
      failures++; $display("FAIL full_ignored: got n=%0d ovf=%b required n=%0d ovf=0",
                           wq.size(), overflow, H);
    end
    $display("test_full_ignored done");
  endtask

  task automatic test_align();
    int k1, bad;
    wq.delete();
    send_line(2 * H - 1, -1, WA0, WA1, k1);
    checks++;
    if (wq.size() != H - 1) begin
      failures++; $display("FAIL align_count: got %0d required %0d", wq.size(), H - 1);
    end
    checks++;
    if ({err_align, err_len} !== 2'b11) begin
      failures++; $display("FAIL align_flags: got al/len=%b required 11", {err_align, err_len});
    end
    clr_pulse();
    checks++;
    if ({err_align, err_len} !== 2'b00) begin
      failures++; $display("FAIL align_clear: got al/len=%b required 00", {err_align, err_len});
    end
    wq.delete();
    send_line(2 * H, -1, WB0, WB1, k1);
    bad = 0;
    foreach (wq[i]) if (wq[i].data[23:0] !== RGB_B || int'(wq[i].x) != i) bad++;
    checks++;
    if (wq.size() != H || bad !== 0) begin
      failures++; $display("FAIL realign: got n=%0d bad=%0d required n=%0d bad=0", wq.size(), bad, H);
    end
    $display("test_align done");
  endtask

  task automatic test_short_frame();
    int k1;
    vsync_pulse();
    clr_pulse();
    for (int l = 0; l < V; l++) send_line(2 * H, -1, WA0, WA1, k1);
    vsync_pulse();
    checks++;
    if ({locked, err_len} !== 2'b10) begin
      failures++; $display("FAIL relock: got locked/len=%b required 10", {locked, err_len});
    end
    for (int l = 0; l < V - 1; l++) send_line(2 * H, -1, WA0, WA1, k1);
    vsync_pulse();
    checks++;
    if ({locked, err_len} !== 2'b01) begin
      failures++; $display("FAIL short_frame: got locked/len=%b required 01", {locked, err_len});
    end
    $display("test_short_frame done");
  endtask

  task automatic test_reset_mid();
    int k1;
    vsync_pulse();
    clr_pulse();
    for (int i = 0; i < 2 * 60 + 1; i++) begin
      de_in = 1'b1;
      d_in = (i % 2 == 0) ? WA0 : WA1;
      tick();
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({wr_en, wr_data, pixel_x, pixel_y, locked, overflow, err_align, err_len} !== '0) begin
      failures++; $display("FAIL reset_mid: got wr_en=%b data=%h x=%0d y=%0d required all 0",
                           wr_en, wr_data, pixel_x, pixel_y);
    end
    ticks(2);
    rst_n = 1'b1;
    wq.delete();
    for (int i = 2 * 60 + 1; i < 2 * H; i++) begin
      d_in = (i % 2 == 0) ? WA0 : WA1;
      tick();
    end
    de_in = 1'b0;
    ticks(16);
    send_line(2 * H, -1, WA0, WA1, k1);
    checks++;
    if (wq.size() != 0) begin
      failures++; $display("FAIL reset_no_write: got %0d writes required 0", wq.size());
    end
    vsync_pulse();
    send_line(2 * H, -1, WA0, WA1, k1);
    checks++;
    if (wq.size() != H || wq[0].data[24] !== 1'b1 || wq[0].x !== 10'd0) begin
      failures++; $display("FAIL reset_resume: got n=%0d sof=%b x=%0d required n=%0d sof=1 x=0",
                           wq.size(), wq[0].data[24], wq[0].x, H);
    end
    $display("test_reset_mid done");
  endtask

  initial begin
    test_reset();
    test_line();
    test_frame();
    test_overflow();
    test_full_ignored();
    test_align();
    test_short_frame();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
